// File: rtl/csa_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial carry-select adder.
package csa_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The slice index register needs at least one bit even when NCHUNK == 1.
    function automatic int calc_idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/csa_serial_adder_chunk.sv
// One carry-select slice: two precomputed ripple sums (cin=0 / cin=1) and a select mux.
module csa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    function automatic logic [CHUNK:0] ripple(input logic [CHUNK-1:0] x,
                                              input logic [CHUNK-1:0] y,
                                              input logic             c);
        logic [CHUNK:0] r;
        logic           cc;
        r  = '0;
        cc = c;
        for (int i = 0; i < CHUNK; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[CHUNK] = cc;
        return r;
    endfunction

    logic [CHUNK:0] sum0_s;
    logic [CHUNK:0] sum1_s;
    logic [CHUNK:0] sel_s;

    assign sum0_s = ripple(a_s, b_s, 1'b0);
    assign sum1_s = ripple(a_s, b_s, 1'b1);

    // Late-arriving carry picks one of the two precomputed sums.
    always_comb begin
        sel_s = sum0_s;
        if (cin) begin
            sel_s = sum1_s;
        end else begin
            sel_s = sum0_s;
        end
    end

    assign s     = sel_s[CHUNK-1:0];
    assign cout  = sel_s[CHUNK];
    // Carry into the top bit recovered from the sum bit and its operands.
    assign c_msb = sel_s[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];

endmodule

// File: rtl/csa_serial_adder.sv
// Digit-serial add/subtract: one CHUNK-bit carry-select slice per cycle, valid/ready on both sides.
module csa_serial_adder
    import csa_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IW     = calc_idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    state_t            state_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IW-1:0]     idx_r;

    int                base_s;
    logic [CHUNK-1:0]  a_slice_s;
    logic [CHUNK-1:0]  b_slice_s;
    logic [CHUNK-1:0]  s_s;
    logic              cout_s;
    logic              c_msb_s;

    // Select the operand slices addressed by the current index.
    always_comb begin
        base_s    = int'(idx_r) * CHUNK;
        a_slice_s = a_r[base_s +: CHUNK];
        b_slice_s = b_r[base_s +: CHUNK];
    end

    csa_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_s   (a_slice_s),
        .b_s   (b_slice_s),
        .cin   (carry_r),
        .s     (s_s),
        .cout  (cout_s),
        .c_msb (c_msb_s)
    );

    // Control FSM plus operand, result, index and carry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        // Subtract is A + ~B + ~borrow_in, so ovf/co share the add path.
                        b_r      <= sub ? ~b : b;
                        carry_r  <= sub ? ~ci : ci;
                        idx_r    <= '0;
                        in_ready <= 1'b0;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    sum[base_s +: CHUNK] <= s_s;
                    carry_r              <= cout_s;
                    if (idx_r == LAST_IDX) begin
                        co        <= cout_s;
                        ovf       <= c_msb_s ^ cout_s;
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_serial_adder.sv
// Directed bench: shared stimulus drives a CHUNK=4 and a CHUNK=16 instance side by side.
module tb_csa_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;

    logic        in_ready4, out_valid4, co4, ovf4;
    logic [15:0] sum4;
    logic        in_ready1, out_valid1, co1, ovf1;
    logic [15:0] sum1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    csa_serial_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready),
        .sum(sum4), .co(co4), .ovf(ovf4)
    );

    csa_serial_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .co(co1), .ovf(ovf1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " in_ready4"},  in_ready4,  1);
        check({tag, " out_valid4"}, out_valid4, 0);
        check({tag, " sum4"},       sum4,       0);
        check({tag, " co4/ovf4"},   {co4, ovf4}, 0);
        check({tag, " in_ready1"},  in_ready1,  1);
        check({tag, " out_valid1"}, out_valid1, 0);
        check({tag, " sum1"},       sum1,       0);
    endtask

    // Present one operation for one cycle, then scramble the operand inputs.
    task automatic start_op(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        a = v.a; b = v.b; ci = v.ci; sub = v.sub;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    endtask

    // Wait for both instances to finish, check latency and result; optionally release.
    task automatic run_vec(input int n, input vec_t v, input bit do_release);
        int lat;
        int lat4;
        int lat1;
        string tag;
        tag  = $sformatf("v%0d", n);
        lat  = 0;
        lat4 = -1;
        lat1 = -1;
        start_op(v);
        while (lat <= 20) begin
            if (out_valid4 && lat4 < 0) lat4 = lat;
            if (out_valid1 && lat1 < 0) lat1 = lat;
            if (lat4 >= 0 && lat1 >= 0) break;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency4"}, lat4, 4);
        check({tag, " latency1"}, lat1, 1);
        check({tag, " sum4"}, sum4, v.exp_sum);
        check({tag, " co4"},  co4,  v.exp_co);
        check({tag, " ovf4"}, ovf4, v.exp_ovf);
        check({tag, " sum1/co1/ovf1"}, {sum1, co1, ovf1}, {v.exp_sum, v.exp_co, v.exp_ovf});
        if (do_release) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, " idle4"}, {in_ready4, out_valid4}, 2'b10);
            check({tag, " idle1"}, {in_ready1, out_valid1}, 2'b10);
        end
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[8] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        vecs[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; ci = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i], 1'b1);
        end

        // Backpressure: hold the result while a new request is offered and ignored.
        run_vec(10, vecs[7], 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = (c == 1);
            a = 16'hAAAA; b = 16'h1111; ci = 1'b1; sub = 1'b1;
            check($sformatf("bp%0d hold4", c), {sum4, co4, ovf4, out_valid4, in_ready4},
                  {16'h5555, 1'b0, 1'b0, 1'b1, 1'b0});
            check($sformatf("bp%0d hold1", c), {sum1, out_valid1, in_ready1},
                  {16'h5555, 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release4", {in_ready4, out_valid4}, 2'b10);
        @(negedge clk);
        check("bp no reaccept4", {in_ready4, out_valid4, sum4}, {2'b10, 16'h5555});

        // Reset with dut4 at slice 2 (dut1 already waiting in DONE).
        rv = '{16'h1111, 16'h1111, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0};
        start_op(rv);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_idx2");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst_idx2 quiet%0d", c), {out_valid4, out_valid1}, 2'b00);
        end
        run_vec(11, vecs[6], 1'b1);

        // Reset during the single RUN cycle of the NCHUNK==1 instance.
        start_op(vecs[5]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_run1");
        run_vec(12, vecs[3], 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
